// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline controller: FSM encoding, output-select codes and
// the decode from a selected hazard condition to the stage-register control pins.
package pipeline_ctrl_pkg;

  localparam int CTRL_ST_BIT = 2;
  localparam int NUM_STAGES  = 4;
  localparam int REG_W       = 5;

  // Performance counter slots
  localparam int NUM_CNT   = 3;
  localparam int CNT_CYCLE = 0;
  localparam int CNT_STALL = 1;
  localparam int CNT_FLUSH = 2;

  typedef enum logic [CTRL_ST_BIT-1:0] {
    CTRL_RUN     = 2'd0,
    CTRL_HALTED  = 2'd1,
    CTRL_RELEASE = 2'd2
  } ctrl_state_e;

  typedef enum logic [1:0] {
    SEL_NORMAL = 2'd0,
    SEL_STALL  = 2'd1,
    SEL_FLUSH  = 2'd2,
    SEL_HALT   = 2'd3
  } ctrl_sel_e;

  // Bit 0 of en/clear is PS1 (IF/ID), bit 3 is PS4 (MEM/WB).
  typedef struct packed {
    logic                  pc_en;
    logic [NUM_STAGES-1:0] en;
    logic [NUM_STAGES-1:0] clear;
  } ctrl_pins_t;

  // Each register gets either its en or its clear, never both.
  function automatic ctrl_pins_t decode_pins(input ctrl_sel_e sel);
    ctrl_pins_t p;
    p.pc_en = 1'b0;
    p.en    = '0;
    p.clear = '0;
    case (sel)
      SEL_HALT: p = '0;
      SEL_FLUSH: begin
        p.pc_en = 1'b1;
        p.en    = 4'b1100;
        p.clear = 4'b0011;
      end
      SEL_STALL: begin
        p.pc_en = 1'b0;
        p.en    = 4'b1100;
        p.clear = 4'b0010;
      end
      default: begin
        p.pc_en = 1'b1;
        p.en    = '1;
      end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Combinational load-use hazard detector between the ID and EX stages.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_req_a,
  input  logic [REG_W-1:0] id_req_b,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic             ex_r_datamem,
  input  logic [REG_W-1:0] ex_req_w,
  output logic             lu
);

  logic hit_a;
  logic hit_b;

  assign hit_a = id_use_a && (id_req_a == ex_req_w);
  assign hit_b = id_use_b && (id_req_b == ex_req_w);
  // A load into $0 never produces a value worth waiting for.
  assign lu    = ex_r_datamem && (ex_req_w != '0) && (hit_a || hit_b);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: resolves halt, mispredict flush and load-use stall into
// stage/PC enables and clears, and keeps wrap-around performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_req_a,
  input  logic [REG_W-1:0] id_req_b,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic             ex_r_datamem,
  input  logic [REG_W-1:0] ex_req_w,
  input  logic             ex_mispredict,
  input  logic             halt_req,
  input  logic             go,
  output logic             pc_en,
  output logic             en_ps1,
  output logic             en_ps2,
  output logic             en_ps3,
  output logic             en_ps4,
  output logic             clear_ps1,
  output logic             clear_ps2,
  output logic             clear_ps3,
  output logic             clear_ps4,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic         lu;
  ctrl_state_e  state_q;
  ctrl_state_e  state_d;
  ctrl_sel_e    sel;
  ctrl_pins_t   pins;
  logic [NUM_CNT-1:0] cnt_inc;
  logic [CNT_W-1:0]   cnt_val [NUM_CNT];

  load_use_detect u_lu (
    .id_req_a     (id_req_a),
    .id_req_b     (id_req_b),
    .id_use_a     (id_use_a),
    .id_use_b     (id_use_b),
    .ex_r_datamem (ex_r_datamem),
    .ex_req_w     (ex_req_w),
    .lu           (lu)
  );

  // Priority: halt, then mispredict (the stalled ID op is wrong-path), then stall.
  always_comb begin
    sel = SEL_NORMAL;
    if (state_q == CTRL_HALTED) begin
      sel = SEL_HALT;
    end else if ((state_q == CTRL_RUN) && halt_req) begin
      sel = SEL_HALT;
    end else if (ex_mispredict) begin
      sel = SEL_FLUSH;
    end else if (lu) begin
      sel = SEL_STALL;
    end
  end

  assign pins = decode_pins(sel);

  always_comb begin
    state_d = state_q;
    case (state_q)
      CTRL_RUN:     if (halt_req) state_d = CTRL_HALTED;
      CTRL_HALTED:  if (go)       state_d = CTRL_RELEASE;
      CTRL_RELEASE: state_d = CTRL_RUN;
      default:      state_d = CTRL_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CTRL_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign pc_en     = pins.pc_en;
  assign en_ps1    = pins.en[0];
  assign en_ps2    = pins.en[1];
  assign en_ps3    = pins.en[2];
  assign en_ps4    = pins.en[3];
  assign clear_ps1 = pins.clear[0];
  assign clear_ps2 = pins.clear[1];
  assign clear_ps3 = pins.clear[2];
  assign clear_ps4 = pins.clear[3];
  assign halted    = (state_q == CTRL_HALTED);

  assign cnt_inc[CNT_CYCLE] = (sel != SEL_HALT);
  assign cnt_inc[CNT_STALL] = (sel == SEL_STALL);
  assign cnt_inc[CNT_FLUSH] = (sel == SEL_FLUSH);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc[gi]) cnt_d = cnt_q + CNT_W'(1);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign cnt_val[gi] = cnt_q;
    end
  endgenerate

  assign cycle_cnt = cnt_val[CNT_CYCLE];
  assign stall_cnt = cnt_val[CNT_STALL];
  assign flush_cnt = cnt_val[CNT_FLUSH];

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed plus randomized checks of pipeline_ctrl against a rule-level model of
// hazard priority, halt/resume sequencing and counters.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] id_req_a, id_req_b, ex_req_w;
  logic       id_use_a, id_use_b, ex_r_datamem, ex_mispredict, halt_req, go;
  logic       pc_en, en_ps1, en_ps2, en_ps3, en_ps4;
  logic       clear_ps1, clear_ps2, clear_ps3, clear_ps4, halted;
  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

  // Narrow-counter instance for the wrap check, idle inputs
  logic       rst4_n;
  logic [4:0] z5;
  logic       z1;
  logic       pc_en4, e1_4, e2_4, e3_4, e4_4, c1_4, c2_4, c3_4, c4_4, halted4;
  logic [3:0] cyc4, stall4, flush4;

  int total = 0;
  int bad   = 0;
  int step_no = 0;

  // Model state: halted flag, "just resumed" flag, counters
  bit          m_halted;
  bit          m_rel;
  logic [31:0] m_cyc, m_stall, m_flush;

  pipeline_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_req_a(id_req_a), .id_req_b(id_req_b), .id_use_a(id_use_a), .id_use_b(id_use_b),
    .ex_r_datamem(ex_r_datamem), .ex_req_w(ex_req_w), .ex_mispredict(ex_mispredict),
    .halt_req(halt_req), .go(go),
    .pc_en(pc_en), .en_ps1(en_ps1), .en_ps2(en_ps2), .en_ps3(en_ps3), .en_ps4(en_ps4),
    .clear_ps1(clear_ps1), .clear_ps2(clear_ps2), .clear_ps3(clear_ps3), .clear_ps4(clear_ps4),
    .halted(halted), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst4_n),
    .id_req_a(z5), .id_req_b(z5), .id_use_a(z1), .id_use_b(z1),
    .ex_r_datamem(z1), .ex_req_w(z5), .ex_mispredict(z1),
    .halt_req(z1), .go(z1),
    .pc_en(pc_en4), .en_ps1(e1_4), .en_ps2(e2_4), .en_ps3(e3_4), .en_ps4(e4_4),
    .clear_ps1(c1_4), .clear_ps2(c2_4), .clear_ps3(c3_4), .clear_ps4(c4_4),
    .halted(halted4), .cycle_cnt(cyc4), .stall_cnt(stall4), .flush_cnt(flush4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_lu();
    return ex_r_datamem && (ex_req_w != 5'd0) &&
           ((id_use_a && id_req_a == ex_req_w) || (id_use_b && id_req_b == ex_req_w));
  endfunction

  function automatic bit model_halting();
    return m_halted || (!m_rel && halt_req);
  endfunction

  // {pc_en, en_ps4..en_ps1, clear_ps4..clear_ps1}
  function automatic logic [8:0] model_pins();
    if (model_halting())  return 9'b0_0000_0000;
    if (ex_mispredict)    return 9'b1_1100_0011;
    if (model_lu())       return 9'b0_1100_0010;
    return 9'b1_1111_0000;
  endfunction

  function automatic logic [8:0] obs_pins();
    return {pc_en, en_ps4, en_ps3, en_ps2, en_ps1, clear_ps4, clear_ps3, clear_ps2, clear_ps1};
  endfunction

  task automatic model_reset();
    m_halted = 1'b0;
    m_rel    = 1'b0;
    m_cyc    = '0;
    m_stall  = '0;
    m_flush  = '0;
  endtask

  task automatic model_clock();
    if (m_halted) begin
      if (go) begin
        m_halted = 1'b0;
        m_rel    = 1'b1;
      end
    end else if (model_halting()) begin
      m_halted = 1'b1;
      m_rel    = 1'b0;
    end else begin
      m_cyc++;
      if (ex_mispredict) m_flush++;
      else if (model_lu()) m_stall++;
      m_rel = 1'b0;
    end
  endtask

  // One transaction: apply inputs at negedge, check pins, clock, check state.
  task automatic step(input logic [4:0] a, input logic [4:0] b, input logic ua, input logic ub,
                      input logic ld, input logic [4:0] w, input logic mp,
                      input logic hr, input logic g);
    logic [8:0] p;
    id_req_a = a; id_req_b = b; id_use_a = ua; id_use_b = ub;
    ex_r_datamem = ld; ex_req_w = w; ex_mispredict = mp; halt_req = hr; go = g;
    #2;
    p = obs_pins();
    chk("pins", 64'(p), 64'(model_pins()));
    model_clock();
    @(posedge clk);
    #1;
    chk("halted", 64'(halted), 64'(m_halted));
    chk("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
    step_no++;
    $display("step %0d a=%0d b=%0d ua=%0b ub=%0b ld=%0b w=%0d mp=%0b halt=%0b go=%0b pins=%09b halted=%0b cyc=%0d stall=%0d flush=%0d",
             step_no, a, b, ua, ub, ld, w, mp, hr, g, p, halted, cycle_cnt, stall_cnt, flush_cnt);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rst4_n = 1'b0; z5 = '0; z1 = 1'b0;
    id_req_a = '0; id_req_b = '0; id_use_a = 1'b0; id_use_b = 1'b0;
    ex_r_datamem = 1'b0; ex_req_w = '0; ex_mispredict = 1'b0; halt_req = 1'b0; go = 1'b0;
    model_reset();

    // Reset state: RUN outputs, counters cleared
    #2;
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_cycle", 64'(cycle_cnt), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    chk("rst_flush", 64'(flush_cnt), 64'd0);
    chk("rst_pins", 64'(obs_pins()), 64'(9'b1_1111_0000));
    @(negedge clk);
    rst_n = 1'b1;

    // 1: load-use on rs
    step(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    chk("t1_stall_cnt", 64'(stall_cnt), 64'd1);
    // load-use on rt
    step(5'd3, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    // 2: load to $0 is no hazard
    step(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("t2_stall_cnt", 64'(stall_cnt), 64'd2);
    // 3: mispredict beats load-use
    step(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    chk("t3_flush_cnt", 64'(flush_cnt), 64'd1);
    chk("t3_stall_cnt", 64'(stall_cnt), 64'd2);
    // go in RUN is ignored
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

    // 4: halt held, go after 5 halted cycles, release ignores halt_req
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("t4_halted_cyc", 64'(cycle_cnt), 64'd5);
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("t4_release_en", 64'(obs_pins()), 64'(9'b1_1111_0000));
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // halt and go together in RUN: halt wins
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);

    // 5: asynchronous reset while halted
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("t5_pre_halted", 64'(halted), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t5_halted", 64'(halted), 64'd0);
    chk("t5_cycle", 64'(cycle_cnt), 64'd0);
    chk("t5_stall", 64'(stall_cnt), 64'd0);
    chk("t5_flush", 64'(flush_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with small register numbers to force matches
    for (int i = 0; i < 200; i++) begin
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 3) == 0));
    end

    // 6: 4-bit cycle counter wraps 15 -> 0
    rst4_n = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      @(posedge clk);
      #1;
      chk("wrap_cyc4", 64'(cyc4), 64'(i % 16));
    end
    chk("wrap_stall4", 64'(stall4), 64'd0);
    chk("wrap_flush4", 64'(flush4), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
